// File: rtl/alu_arbiter_pkg.sv
// Shared widths, command encoding and operand types for the column operators and the ALU.
// Pure definitions: no latency, no flow control.
package alu_arbiter_pkg;

  localparam int CMD_SIZE_LOG2 = 2;
  localparam int NUM_SIZE      = 16;

  typedef logic [2**CMD_SIZE_LOG2-1:0] cmd_t;
  typedef logic [NUM_SIZE-1:0]         num_t;

  localparam cmd_t CMD_NOP = '0;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus binary index, search starts at ptr.
// Latency: grant is combinational from req; ptr advances on the granting edge. No backpressure.
module rr_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Candidate order is ptr, ptr+1, ... wrapping at N; the first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU among NUM_REQ requesters and routes each result back by tag.
// Latency: ALU_LATENCY+1 cycles grant-to-result; request side valid/ready, no response backpressure.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 2,
  parameter int CMD_W       = 2**CMD_SIZE_LOG2,
  parameter int NUM_W       = NUM_SIZE,
  localparam int IF_W       = $clog2(ALU_LATENCY + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  input  logic [NUM_REQ*NUM_W-1:0] req_in1,
  input  logic [NUM_REQ*NUM_W-1:0] req_in2,
  output logic [CMD_W-1:0]         alu_cmd,
  output logic [NUM_W-1:0]         alu_in1,
  output logic [NUM_W-1:0]         alu_in2,
  input  logic [NUM_W-1:0]         alu_out,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [NUM_W-1:0]         rsp_out,
  output logic [IF_W-1:0]          in_flight
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               issue;
  logic               retire;
  logic [CMD_W-1:0]   sel_cmd;
  logic [NUM_W-1:0]   sel_in1;
  logic [NUM_W-1:0]   sel_in2;
  tag_t               tag [ALU_LATENCY];

  // Masking requests in reset keeps ready low and the pointer parked at 0.
  assign arb_req = req_valid & {NUM_REQ{reset}};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign issue     = |gnt;
  assign retire    = tag[ALU_LATENCY-1].vld;

  always_comb begin
    sel_cmd = '0;
    sel_in1 = '0;
    sel_in2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_cmd = req_cmd[i*CMD_W +: CMD_W];
        sel_in1 = req_in1[i*NUM_W +: NUM_W];
        sel_in2 = req_in2[i*NUM_W +: NUM_W];
      end
    end
  end

  // Idle cycles present a NOP with zero operands so the ALU never sees stale data.
  always_ff @(posedge clk) begin
    if (!reset || !issue) begin
      alu_cmd <= CMD_W'(CMD_NOP);
      alu_in1 <= '0;
      alu_in2 <= '0;
    end else begin
      alu_cmd <= sel_cmd;
      alu_in1 <= sel_in1;
      alu_in2 <= sel_in2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < ALU_LATENCY; s++) begin
        tag[s] <= '0;
      end
    end else begin
      tag[0] <= tag_t'{vld: issue, idx: gnt_idx};
      for (int s = 1; s < ALU_LATENCY; s++) begin
        tag[s] <= tag[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_out   <= '0;
    end else begin
      rsp_valid <= retire ? (NUM_REQ'(1) << tag[ALU_LATENCY-1].idx) : '0;
      if (retire) begin
        rsp_out <= alu_out;
      end
    end
  end

  // Issue and retire on the same edge cancel, so the count stays put.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_flight <= '0;
    end else begin
      in_flight <= in_flight + IF_W'(issue) - IF_W'(retire);
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
  a_gnt_valid:  assert property (@(posedge clk) disable iff (!reset) (req_ready & ~req_valid) == '0);
  a_if_bound:   assert property (@(posedge clk) disable iff (!reset) in_flight <= IF_W'(ALU_LATENCY));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a two-stage ALU model and a response scoreboard.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int L  = 2;
  localparam int CW = 4;
  localparam int NW = 16;

  localparam logic [3:0] C_ADD = 4'd1;
  localparam logic [3:0] C_SUB = 4'd2;
  localparam logic [3:0] C_AND = 4'd3;
  localparam logic [3:0] C_XOR = 4'd4;

  logic                 clk;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*CW-1:0]     req_cmd;
  logic [NR*NW-1:0]     req_in1;
  logic [NR*NW-1:0]     req_in2;
  logic [CW-1:0]        alu_cmd;
  logic [NW-1:0]        alu_in1;
  logic [NW-1:0]        alu_in2;
  logic [NW-1:0]        alu_out;
  logic [NW-1:0]        alu_q;
  logic [NR-1:0]        rsp_valid;
  logic [NW-1:0]        rsp_out;
  logic [$clog2(L+1)-1:0] in_flight;

  alu_arbiter #(.NUM_REQ(NR), .ALU_LATENCY(L), .CMD_W(CW), .NUM_W(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .alu_cmd   (alu_cmd),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_out   (rsp_out),
    .in_flight (in_flight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NW-1:0] alu_f(input logic [CW-1:0] c, input logic [NW-1:0] a, input logic [NW-1:0] b);
    case (c)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_AND:   return a & b;
      C_XOR:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  // One register stage: inputs driven at edge E are sampleable at edge E+2.
  always @(posedge clk) alu_q <= alu_f(alu_cmd, alu_in1, alu_in2);
  assign alu_out = alu_q;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic [NW-1:0] res;
    int            at;
  } exp_t;

  exp_t          sb[$];
  exp_t          got;
  logic [NW-1:0] exp_res [NR];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp at cycle %0d: rsp_valid=%b rsp_out=%0h", cyc, rsp_valid, rsp_out);
      end else begin
        got = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << got.idx);
        chk("rsp_out", 32'(rsp_out), 32'(got.res));
        chk("rsp_cycle", cyc, got.at);
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] c, input logic [NW-1:0] a,
                         input logic [NW-1:0] b, input logic [NW-1:0] r);
    req_cmd[i*CW +: CW] = c;
    req_in1[i*NW +: NW] = a;
    req_in2[i*NW +: NW] = b;
    exp_res[i]          = r;
  endtask

  task automatic step(input logic [3:0] exp_rdy, input bit drop, input int exp_if,
                      input bit do_alu = 1'b0, input logic [3:0] e_cmd = '0,
                      input logic [NW-1:0] e_in1 = '0, input logic [NW-1:0] e_in2 = '0);
    exp_t e;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_if >= 0) chk("in_flight", 32'(in_flight), exp_if);
    if (do_alu) begin
      chk("alu_cmd", 32'(alu_cmd), 32'(e_cmd));
      chk("alu_in1", 32'(alu_in1), 32'(e_in1));
      chk("alu_in2", 32'(alu_in2), 32'(e_in2));
    end
    for (int i = 0; i < NR; i++) begin
      if (exp_rdy[i]) begin
        e.idx = i;
        e.res = exp_res[i];
        e.at  = cyc + 1 + L;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (drop) req_valid = req_valid & ~exp_rdy;
  endtask

  logic [3:0] rr_seq [4];

  initial begin
    reset     = 1'b0;
    req_valid = '1;
    req_cmd   = '0;
    req_in1   = '0;
    req_in2   = '0;
    for (int i = 0; i < NR; i++) exp_res[i] = '0;
    rr_seq[0] = 4'b0001;
    rr_seq[1] = 4'b0010;
    rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000;

    // Reset state, with every requester asking.
    step(4'b0000, 0, -1);
    step(4'b0000, 0, 0, 1, 4'd0, 16'd0, 16'd0);
    chk("reset_rsp_out", 32'(rsp_out), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    reset     = 1'b1;

    // Single requester 1: ADD 5+7.
    set_req(1, C_ADD, 16'd5, 16'd7, 16'd12);
    req_valid = 4'b0010;
    step(4'b0010, 1, 0);
    step(4'b0000, 0, 1, 1, C_ADD, 16'd5, 16'd7);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);

    // Fairness skip from ptr=2 with only 0 and 3 asking.
    set_req(0, C_SUB, 16'd20, 16'd8, 16'd12);
    set_req(3, C_AND, 16'h00F0, 16'h0FF0, 16'h00F0);
    req_valid = 4'b1001;
    step(4'b1000, 0, 0);
    step(4'b0001, 0, 1);
    step(4'b1000, 0, 2);
    req_valid = '0;
    step(4'b0000, 0, 2);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);

    // Requester 2 holds its operands for three cycles behind 3, 0, 1.
    set_req(2, C_ADD, 16'd100, 16'd23, 16'd123);
    req_valid = 4'b0100;
    step(4'b0100, 1, 0);
    set_req(3, C_ADD, 16'd1, 16'd1, 16'd2);
    set_req(0, C_SUB, 16'd50, 16'd1, 16'd49);
    set_req(1, C_AND, 16'hFF00, 16'h0F0F, 16'h0F00);
    set_req(2, C_XOR, 16'hA5A5, 16'h0FF0, 16'hAA55);
    req_valid = 4'b1111;
    step(4'b1000, 1, 1);
    step(4'b0001, 1, 2);
    step(4'b0010, 1, 2);
    step(4'b0100, 1, 2);
    step(4'b0000, 0, 2, 1, C_XOR, 16'hA5A5, 16'h0FF0);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);

    // Two ops issued, then reset lands while both are still in the pipe.
    set_req(3, C_ADD, 16'd3, 16'd4, 16'd7);
    set_req(0, C_ADD, 16'd9, 16'd9, 16'd18);
    req_valid = 4'b1001;
    step(4'b1000, 1, 0);
    step(4'b0001, 1, 1);
    reset     = 1'b0;
    req_valid = 4'b1111;
    sb.delete();
    step(4'b0000, 0, -1);
    step(4'b0000, 0, 0, 1, 4'd0, 16'd0, 16'd0);

    // All four continuously valid straight out of reset.
    set_req(0, C_ADD, 16'd10, 16'd20, 16'd30);
    set_req(1, C_SUB, 16'd100, 16'd40, 16'd60);
    set_req(2, C_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0);
    set_req(3, C_AND, 16'h1234, 16'h00FF, 16'h0034);
    reset = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(rr_seq[k % 4], 0, (k == 0) ? 0 : ((k == 1) ? 1 : 2));
    end
    req_valid = '0;
    step(4'b0000, 0, 2);
    step(4'b0000, 0, 1);

    // Idle for ten cycles; pointer must stay at 1.
    for (int k = 0; k < 10; k++) begin
      step(4'b0000, 0, 0, 1, 4'd0, 16'd0, 16'd0);
    end
    set_req(0, C_SUB, 16'd7, 16'd2, 16'd5);
    set_req(2, C_ADD, 16'd1000, 16'd24, 16'd1024);
    req_valid = 4'b0101;
    step(4'b0100, 1, 0);
    step(4'b0001, 1, 1);
    step(4'b0000, 0, 2);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
